// File: rtl/core_prefetch.sv
// Bus interface unit: prefetches code bytes at CS:IP into a small byte queue and
// arbitrates core data reads/writes onto the shared single-port memory bus.
module core_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [15:0] cs_in,
  input  logic [15:0] ip_in,
  input  logic        q_pop,
  output logic        q_valid,
  output logic [7:0]  q_data,
  output logic [15:0] q_ip,
  output logic [4:0]  q_count,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [19:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state, next;

  logic [7:0]    buffer [DEPTH];
  logic [AW-1:0] head, tail;
  logic [4:0]    count;
  logic [15:0]   fetch_cs, fetch_ip;
  logic [15:0]   seg, off;
  logic [19:0]   fetch_addr;
  logic          drop;
  logic          push, pop;

  // A flush in the same cycle as the IDLE decision retargets the next fetch immediately.
  assign seg        = flush ? cs_in : fetch_cs;
  assign off        = flush ? ip_in : fetch_ip;
  assign fetch_addr = {seg, 4'h0} + {4'h0, off};

  assign push = (state == FETCH) && mem_ready && !drop && !flush;
  assign pop  = q_pop && (count != 5'd0) && !flush;

  assign q_valid = (count != 5'd0);
  assign q_data  = buffer[head];
  assign q_count = count;

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (d_req) next = DATA;
        else if (flush || count < 5'(DEPTH)) next = FETCH;
      end
      FETCH, DATA: if (mem_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Data handshake: d_req is held (with stable d_we/d_addr/d_wdata) until d_ack, which
  // pulses for one cycle after the memory edge; the core drops d_req in that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 20'h0;
      mem_wdata <= 8'h0;
      d_ack     <= 1'b0;
      d_rdata   <= 8'h0;
      drop      <= 1'b0;
    end else begin
      d_ack <= (state == DATA) && mem_ready;
      if ((state == DATA) && mem_ready && !mem_we) d_rdata <= mem_rdata;
      if (state == IDLE && next == DATA) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (state == IDLE && next == FETCH) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= fetch_addr;
      end else if (state != IDLE && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      // An in-flight fetch overtaken by a flush still finishes on the bus; its byte is discarded.
      if (state == FETCH && mem_ready) drop <= 1'b0;
      else if (state == FETCH && flush) drop <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= 5'd0;
      q_ip     <= 16'h0;
      fetch_cs <= 16'h0;
      fetch_ip <= 16'h0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= 5'd0;
      q_ip     <= ip_in;
      fetch_cs <= cs_in;
      fetch_ip <= ip_in;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        fetch_ip <= fetch_ip + 16'd1;
      end
      if (pop) begin
        head <= head + 1'b1;
        q_ip <= q_ip + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) buffer[tail] <= mem_rdata;
  end

endmodule

// File: tb/tb_core_prefetch.sv
// Randomized bench for core_prefetch: a memory model answers bus cycles and a queue-level
// reference model predicts queue contents, IPs, bus addresses and data acks.
module tb_core_prefetch;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, flush, q_pop, q_valid;
  logic [15:0] cs_in, ip_in, q_ip;
  logic [7:0]  q_data, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [4:0]  q_count;
  logic        d_req, d_we, d_ack, mem_we, mem_req, mem_ready;
  logic [19:0] d_addr, mem_addr;

  function automatic logic [7:0] mem_fn(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {a[19:16], 4'h5};
  endfunction

  function automatic logic [19:0] phys(input logic [15:0] cs, input logic [15:0] ip);
    logic [31:0] s;
    s = {16'h0, cs} * 32'd16 + {16'h0, ip};
    return s[19:0];
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  core_prefetch #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush), .cs_in(cs_in), .ip_in(ip_in),
    .q_pop(q_pop), .q_valid(q_valid), .q_data(q_data), .q_ip(q_ip), .q_count(q_count),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, ack_count = 0;
  int ready_pct = 100, pop_pct = 0, dreq_pct = 0, flush_pct = 0;
  bit force_reset = 1'b0, force_flush = 1'b0;
  logic [15:0] f_cs, f_ip;

  logic [7:0]  exp_q[$];
  logic [15:0] model_cs = 16'h0, pop_ip = 16'h0, fetch_ip = 16'h0;
  logic [19:0] cyc_addr = 20'h0;
  logic [7:0]  exp_rdata = 8'h0;
  bit armed = 1'b0, exp_req_valid = 1'b0, exp_req = 1'b0, exp_ack = 1'b0;
  bit cyc_data = 1'b0, cyc_we = 1'b0, cyc_stale = 1'b0;
  bit prev_req = 1'b0, prev_dreq = 1'b0, prev_reset = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample and check at the falling edge, drive the next inputs, advance the model.
  task automatic cycle();
    bit s_req, complete, push, pop;
    int depth_before;
    @(negedge clock);
    if (armed) begin
      if (exp_req_valid) check("mem_req", 32'(mem_req), 32'(exp_req));
      check("q_count", 32'(q_count), exp_q.size());
      check("q_bound", 32'(q_count <= 5'(DEPTH)), 32'd1);
      check("q_valid", 32'(q_valid), 32'(exp_q.size() != 0));
      check("q_ip", 32'(q_ip), 32'(pop_ip));
      if (exp_q.size() != 0) check("q_data", 32'(q_data), 32'(exp_q[0]));
      check("d_ack", 32'(d_ack), 32'(exp_ack));
      check("d_rdata", 32'(d_rdata), 32'(exp_rdata));
      if (!mem_req) check("mem_we_idle", 32'(mem_we), 32'd0);
      if (prev_reset) begin
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
      end
      if (mem_req && !prev_req) begin
        cyc_data = prev_dreq;
        if (cyc_data) begin
          cyc_addr = d_addr;
          cyc_we   = d_we;
          check("data_addr", 32'(mem_addr), 32'(d_addr));
          check("data_we", 32'(mem_we), 32'(d_we));
          if (d_we) check("data_wdata", 32'(mem_wdata), 32'(d_wdata));
        end else begin
          check("fetch_addr", 32'(mem_addr), 32'(phys(model_cs, fetch_ip)));
          check("fetch_we", 32'(mem_we), 32'd0);
        end
      end
    end
    if (d_ack === 1'b1) ack_count++;
    s_req = (mem_req === 1'b1);

    reset = force_reset;
    flush = force_flush || chance(flush_pct);
    if (flush) begin
      cs_in = force_flush ? f_cs : 16'($urandom);
      ip_in = force_flush ? f_ip : 16'($urandom);
    end
    q_pop     = chance(pop_pct);
    mem_ready = chance(ready_pct);
    if (d_ack === 1'b1) d_req = 1'b0;
    else if (!d_req && chance(dreq_pct)) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_addr  = 20'($urandom);
      d_wdata = 8'($urandom);
    end

    if (reset) begin
      exp_q.delete();
      model_cs = 16'h0; pop_ip = 16'h0; fetch_ip = 16'h0;
      exp_req_valid = 1'b1; exp_req = 1'b0; exp_ack = 1'b0; exp_rdata = 8'h0;
      cyc_data = 1'b0; cyc_stale = 1'b0; prev_req = 1'b0; prev_dreq = 1'b0;
      prev_reset = 1'b1; armed = 1'b1;
      return;
    end
    complete     = s_req && mem_ready;
    depth_before = exp_q.size();
    exp_req_valid = 1'b1;
    exp_req = s_req ? !mem_ready : (d_req || flush || depth_before < DEPTH);
    exp_ack = complete && cyc_data;
    if (complete && cyc_data && !cyc_we) exp_rdata = mem_fn(cyc_addr);
    push = complete && !cyc_data && !cyc_stale && !flush;
    pop  = q_pop && (depth_before != 0) && !flush;
    if (flush) begin
      exp_q.delete();
      model_cs = cs_in; pop_ip = ip_in; fetch_ip = ip_in;
      if (s_req && !cyc_data && !complete) cyc_stale = 1'b1;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        pop_ip = pop_ip + 16'd1;
      end
      if (push) begin
        exp_q.push_back(mem_fn(phys(model_cs, fetch_ip)));
        fetch_ip = fetch_ip + 16'd1;
      end
    end
    if (complete) cyc_stale = 1'b0;
    prev_req = s_req; prev_dreq = d_req; prev_reset = 1'b0;
  endtask

  task automatic run(input int n, input int rdy, input int pp, input int dp, input int fp);
    ready_pct = rdy; pop_pct = pp; dreq_pct = dp; flush_pct = fp;
    repeat (n) cycle();
  endtask

  task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
    force_flush = 1'b1; f_cs = cs; f_ip = ip;
    cycle();
    force_flush = 1'b0;
  endtask

  initial begin
    int ack0;
    bit seen;
    reset = 1'b1; flush = 1'b0; q_pop = 1'b0; cs_in = 16'h0; ip_in = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 20'h0; d_wdata = 8'h0; mem_ready = 1'b1;

    force_reset = 1'b1;
    run(3, 100, 0, 0, 0);
    force_reset = 1'b0;

    // Fill from F000:FFF0 with no pops; fetching must stop at DEPTH.
    run(0, 100, 0, 0, 0);
    do_flush(16'hF000, 16'hFFF0);
    run(20, 100, 0, 0, 0);
    check("t1_full", 32'(q_count), 32'(DEPTH));

    // 1 MiB wrap, then IP wrap within the segment while popping.
    do_flush(16'hFFFF, 16'h0010);
    run(4, 100, 0, 0, 0);
    do_flush(16'h1234, 16'hFFFC);
    run(30, 100, 100, 0, 0);

    // Data read while the queue is full.
    do_flush(16'hABCD, 16'h0000);
    run(20, 100, 0, 0, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h12345; d_wdata = 8'h00;
    ack0 = ack_count;
    run(10, 100, 0, 0, 0);
    check("t3_acks", 32'(ack_count - ack0), 32'd1);
    check("t3_rdata", 32'(d_rdata), 32'(mem_fn(20'h12345)));

    // Stalled fetch overtaken by a flush: late byte dropped, refetch from the new CS:IP.
    ready_pct = 0;
    do_flush(16'h2000, 16'h0100);
    cycle();
    do_flush(16'h3000, 16'h0200);
    cycle();
    ready_pct = 100;
    cycle();
    cycle();
    check("t4_drop", 32'(q_count), 32'd0);
    run(20, 100, 100, 0, 0);

    // Pop every cycle at full bus speed.
    run(60, 100, 100, 0, 0);

    // Reset in the middle of a stalled data write.
    d_req = 1'b1; d_we = 1'b1; d_addr = 20'h5A5A5; d_wdata = 8'h3C;
    ready_pct = 0; pop_pct = 0; dreq_pct = 0; flush_pct = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = (mem_req === 1'b1) && (mem_we === 1'b1);
    end
    check("t6_start", 32'(seen), 32'd1);
    d_req = 1'b0;
    force_reset = 1'b1;
    ack0 = ack_count;
    cycle();
    force_reset = 1'b0;
    run(2, 100, 0, 0, 0);
    check("t6_noack", 32'(ack_count - ack0), 32'd0);

    for (int p = 0; p < 40; p++) begin
      run(50, chance(30) ? 100 : int'($urandom_range(90, 30)),
          int'($urandom_range(100)), int'($urandom_range(30)), int'($urandom_range(5)));
    end
    run(10, 100, 100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
